// File: rtl/icache_pkg.sv
// Purpose: shared state type and address-field helpers for the instruction cache.
// Latency: none; the package holds types and pure functions only.
// Backpressure: none.
//
// The address helpers are shared with the lookup logic. All of them work on a
// 64-bit container. Callers size-cast the result down to their field width.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    INVAL  = 2'd1,
    READ   = 2'd2,
    COMMIT = 2'd3
  } fill_state_t;

  // The tag is whatever remains after the byte offset, the word offset and the index.
  function automatic int calc_tag_width(input int addr_w, input int index_w, input int block_w);
    return addr_w - index_w - block_w - 2;
  endfunction

  function automatic logic [63:0] addr_word(input logic [63:0] addr, input int block_w);
    return (addr >> 2) & ((64'd1 << block_w) - 64'd1);
  endfunction

  function automatic logic [63:0] addr_index(input logic [63:0] addr, input int index_w,
                                             input int block_w);
    return (addr >> (block_w + 2)) & ((64'd1 << index_w) - 64'd1);
  endfunction

  function automatic logic [63:0] addr_tag(input logic [63:0] addr, input int index_w,
                                           input int block_w);
    return addr >> (index_w + block_w + 2);
  endfunction

endpackage

// File: rtl/icache_fill.sv
// Purpose: icache line-refill engine. It invalidates the line, bursts the line from memory, then commits tag and valid.
// Latency: miss -> INVAL (1) -> 2**BLOCK_WIDTH READ beats (plus wait cycles) -> COMMIT; o_done is seen at cycle 2+2**BLOCK_WIDTH with zero-wait acks.
// Backpressure: the memory side stalls the burst by withholding i_mem_ack. A new miss is dropped while busy and is not queued.
//
// Ports:
//   i_clock, i_reset (synchronous, active-high)
//   i_miss / i_miss_addr        refill request from lookup, sampled in IDLE only
//   o_busy / o_done             status; o_done pulses for one cycle in COMMIT
//   o_mem_rd / o_mem_addr       word-aligned read request, held until i_mem_ack
//   i_mem_data / i_mem_ack      read return
//   o_cache_wr/_addr/_data      data-array write, driven combinationally in the ack cycle
//   o_tag_wr/_index/o_tag/o_tag_valid   tag-store write (invalidate in INVAL, validate in COMMIT)
// Config: define ICACHE_FILL_CWF_EN for critical-word-first bursts. Otherwise every burst starts at word 0.
module icache_fill
  import icache_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_WIDTH = 5,
  parameter int BLOCK_WIDTH = 2,
  localparam int TAG_WIDTH  = calc_tag_width(ADDR_WIDTH, INDEX_WIDTH, BLOCK_WIDTH)
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  input  logic                           i_miss,
  input  logic [ADDR_WIDTH-1:0]          i_miss_addr,
  output logic                           o_busy,
  output logic                           o_done,
  output logic                           o_mem_rd,
  output logic [ADDR_WIDTH-1:0]          o_mem_addr,
  input  logic [DATA_WIDTH-1:0]          i_mem_data,
  input  logic                           i_mem_ack,
  output logic                           o_cache_wr,
  output logic [INDEX_WIDTH+BLOCK_WIDTH-1:0] o_cache_addr,
  output logic [DATA_WIDTH-1:0]          o_cache_data,
  output logic                           o_tag_wr,
  output logic [INDEX_WIDTH-1:0]         o_tag_index,
  output logic [TAG_WIDTH-1:0]           o_tag,
  output logic                           o_tag_valid
);

  localparam int LINE_WORDS = 2 ** BLOCK_WIDTH;
  localparam logic [BLOCK_WIDTH:0] LAST_BEAT = (BLOCK_WIDTH + 1)'(LINE_WORDS - 1);

  fill_state_t state_q, state_d;

  logic [TAG_WIDTH-1:0]   tag_q;
  logic [INDEX_WIDTH-1:0] index_q;
  logic [BLOCK_WIDTH-1:0] word_q;   // wraps around the line
  logic [BLOCK_WIDTH:0]   beat_q;   // counts acks and ends the burst

  logic                   accept;
  logic                   beat_ack;
  logic [BLOCK_WIDTH-1:0] start_word;

  assign accept   = (state_q == IDLE) && i_miss;
  assign beat_ack = (state_q == READ) && i_mem_ack;

`ifdef ICACHE_FILL_CWF_EN
  assign start_word = BLOCK_WIDTH'(addr_word(64'(i_miss_addr), BLOCK_WIDTH));
`else
  assign start_word = '0;
`endif

  // State register
  always_ff @(posedge i_clock) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (i_miss) state_d = INVAL;
      INVAL:   state_d = READ;
      READ:    if (i_mem_ack && (beat_q == LAST_BEAT)) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latched request and burst counters
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      tag_q   <= '0;
      index_q <= '0;
      word_q  <= '0;
      beat_q  <= '0;
    end else if (accept) begin
      tag_q   <= TAG_WIDTH'(addr_tag(64'(i_miss_addr), INDEX_WIDTH, BLOCK_WIDTH));
      index_q <= INDEX_WIDTH'(addr_index(64'(i_miss_addr), INDEX_WIDTH, BLOCK_WIDTH));
      word_q  <= start_word;
      beat_q  <= '0;
    end else if (beat_ack) begin
      word_q  <= word_q + BLOCK_WIDTH'(1);
      beat_q  <= beat_q + (BLOCK_WIDTH + 1)'(1);
    end
  end

  // Outputs. Address, data and tag fields are zeroed outside their own state.
  always_comb begin
    o_busy       = (state_q != IDLE);
    o_done       = 1'b0;
    o_mem_rd     = 1'b0;
    o_mem_addr   = '0;
    o_cache_wr   = 1'b0;
    o_cache_addr = '0;
    o_cache_data = '0;
    o_tag_wr     = 1'b0;
    o_tag_index  = '0;
    o_tag        = '0;
    o_tag_valid  = 1'b0;
    unique case (state_q)
      INVAL: begin
        o_tag_wr    = 1'b1;
        o_tag_index = index_q;
        o_tag       = tag_q;
      end
      READ: begin
        o_mem_rd   = 1'b1;
        o_mem_addr = {tag_q, index_q, word_q, 2'b00};
        if (i_mem_ack) begin
          o_cache_wr   = 1'b1;
          o_cache_addr = {index_q, word_q};
          o_cache_data = i_mem_data;
        end
      end
      COMMIT: begin
        o_done      = 1'b1;
        o_tag_wr    = 1'b1;
        o_tag_index = index_q;
        o_tag       = tag_q;
        o_tag_valid = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_icache_fill.sv
// Purpose: directed self-checking bench for icache_fill at default parameters.
// Latency: n/a.
// Backpressure: the bench delays i_mem_ack on chosen beats.
module tb_icache_fill;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 5;
  localparam int BW = 2;
  localparam int TW = AW - IW - BW - 2;
  localparam logic [DW-1:0] DBASE = 32'hA000_0000;

  logic          i_clock = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_miss = 1'b0;
  logic [AW-1:0] i_miss_addr = '0;
  logic [DW-1:0] i_mem_data = '0;
  logic          i_mem_ack = 1'b0;
  logic          o_busy, o_done, o_mem_rd, o_cache_wr, o_tag_wr, o_tag_valid;
  logic [AW-1:0] o_mem_addr;
  logic [IW+BW-1:0] o_cache_addr;
  logic [DW-1:0] o_cache_data;
  logic [IW-1:0] o_tag_index;
  logic [TW-1:0] o_tag;

  icache_fill dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .o_busy(o_busy), .o_done(o_done), .o_mem_rd(o_mem_rd), .o_mem_addr(o_mem_addr),
    .i_mem_data(i_mem_data), .i_mem_ack(i_mem_ack), .o_cache_wr(o_cache_wr),
    .o_cache_addr(o_cache_addr), .o_cache_data(o_cache_data), .o_tag_wr(o_tag_wr),
    .o_tag_index(o_tag_index), .o_tag(o_tag), .o_tag_valid(o_tag_valid)
  );

  always #5 i_clock = ~i_clock;

  int n_tests = 0;
  int n_fail  = 0;

  logic [AW-1:0]    exp_mem [4];
  logic [IW+BW-1:0] exp_cad [4];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_busy"},     64'(o_busy), 0);
    chk({tag, "_done"},     64'(o_done), 0);
    chk({tag, "_mem_rd"},   64'(o_mem_rd), 0);
    chk({tag, "_mem_addr"}, 64'(o_mem_addr), 0);
    chk({tag, "_cache_wr"}, 64'(o_cache_wr), 0);
    chk({tag, "_cache_ad"}, 64'(o_cache_addr), 0);
    chk({tag, "_cache_dt"}, 64'(o_cache_data), 0);
    chk({tag, "_tag_wr"},   64'(o_tag_wr), 0);
    chk({tag, "_tag_idx"},  64'(o_tag_index), 0);
    chk({tag, "_tag"},      64'(o_tag), 0);
    chk({tag, "_valid"},    64'(o_tag_valid), 0);
  endtask

  // Run one refill, with the miss raised in cycle 0. slow_beat/slow_n give the ack wait.
  // pulse_miss raises a foreign miss during beat 1. rst_beat>=0 resets after that many acks.
  task automatic refill(input logic [AW-1:0] addr, input logic [TW-1:0] etag,
                        input logic [IW-1:0] eidx, input int slow_beat, input int slow_n,
                        input int exp_done, input bit pulse_miss, input int rst_beat);
    int cyc, beats, waited, writes;
    bit fin;
    cyc = 0; beats = 0; waited = 0; writes = 0; fin = 0;
    i_miss = 1'b1; i_miss_addr = addr;
    #1;
    chk("c0_busy", 64'(o_busy), 0);
    tick(); cyc = 1;
    i_miss = 1'b0; i_miss_addr = '0;
    #1;
    chk("inval_tag_wr", 64'(o_tag_wr), 1);
    chk("inval_valid",  64'(o_tag_valid), 0);
    chk("inval_tag",    64'(o_tag), 64'(etag));
    chk("inval_index",  64'(o_tag_index), 64'(eidx));
    chk("inval_mem_rd", 64'(o_mem_rd), 0);
    while (!fin && cyc < 40) begin
      tick(); cyc++;
      i_mem_ack = 1'b0; i_miss = 1'b0;
      if (o_done) begin
        fin = 1;
        chk("done_cycle",   64'(cyc), 64'(exp_done));
        chk("commit_tagwr", 64'(o_tag_wr), 1);
        chk("commit_valid", 64'(o_tag_valid), 1);
        chk("commit_tag",   64'(o_tag), 64'(etag));
        chk("commit_index", 64'(o_tag_index), 64'(eidx));
        chk("beats",        64'(beats), 4);
        chk("writes",       64'(writes), 4);
      end else if (o_mem_rd) begin
        chk("mem_addr", 64'(o_mem_addr), 64'(exp_mem[beats & 3]));
        if (rst_beat >= 0 && beats == rst_beat) begin
          i_reset = 1'b1;
          tick();
          i_reset = 1'b0;
          #1;
          check_quiet("post_rst");
          tick();
          check_quiet("post_rst2");
          return;
        end
        if (pulse_miss && beats == 1) begin
          i_miss = 1'b1; i_miss_addr = 32'h0000_2000;
        end
        if (beats == slow_beat && waited < slow_n) begin
          waited++;
          #1;
          chk("wait_no_wr", 64'(o_cache_wr), 0);
        end else begin
          i_mem_ack = 1'b1; i_mem_data = DBASE + DW'(beats);
          #1;
          chk("cache_addr", 64'(o_cache_addr), 64'(exp_cad[beats & 3]));
          chk("cache_data", 64'(o_cache_data), 64'(DBASE + DW'(beats)));
          beats++;
        end
      end else begin
        #1;
      end
      if (o_cache_wr) writes++;
    end
    i_mem_ack = 1'b0; i_miss = 1'b0;
    if (!fin) chk("timeout", 1, 0);
    tick();
    chk("idle_after_commit", 64'(o_busy), 0);
  endtask

  task automatic set_exp_1234();
`ifdef ICACHE_FILL_CWF_EN
    exp_mem = '{32'h1234, 32'h1238, 32'h123C, 32'h1230};
    exp_cad = '{7'h0D, 7'h0E, 7'h0F, 7'h0C};
`else
    exp_mem = '{32'h1230, 32'h1234, 32'h1238, 32'h123C};
    exp_cad = '{7'h0C, 7'h0D, 7'h0E, 7'h0F};
`endif
  endtask

  task automatic set_exp_abc8();
`ifdef ICACHE_FILL_CWF_EN
    exp_mem = '{32'hABC8, 32'hABCC, 32'hABC0, 32'hABC4};
    exp_cad = '{7'h72, 7'h73, 7'h70, 7'h71};
`else
    exp_mem = '{32'hABC0, 32'hABC4, 32'hABC8, 32'hABCC};
    exp_cad = '{7'h70, 7'h71, 7'h72, 7'h73};
`endif
  endtask

  initial begin
    i_reset = 1'b1;
    tick(); tick();
    check_quiet("reset");
    i_reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      i_mem_ack  = (i % 2 == 0);
      i_mem_data = 32'hDEAD_0000 + 32'(i);
      #1;
      check_quiet("idle_ack");
      tick();
    end
    i_mem_ack = 1'b0;

    // Zero-wait refill of 0x1234: tag 0x9, index 0x03
    set_exp_1234();
    refill(32'h0000_1234, 23'h9, 5'h03, -1, 0, 6, 1'b0, -1);
    // Back-to-back miss, second word acked 3 cycles late
    refill(32'h0000_1234, 23'h9, 5'h03, 1, 3, 9, 1'b0, -1);
    // Foreign miss pulsed mid-burst must not disturb the line
    refill(32'h0000_1234, 23'h9, 5'h03, -1, 0, 6, 1'b1, -1);
    // Reset after the second ack
    refill(32'h0000_1234, 23'h9, 5'h03, -1, 0, 6, 1'b0, 2);
    // A following miss completes normally: 0xABC8 has tag 0x55, index 0x1C, word 2
    set_exp_abc8();
    refill(32'h0000_ABC8, 23'h55, 5'h1C, -1, 0, 6, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
